asym_ram_byte_fifo_ctrl: RTL and testbench
==========================================

Name: asym_ram_byte_fifo_ctrl

Overview:
- Write/read controller that turns the 8-bit-write / 64-bit-async-read simple dual-port RAM into a byte-in, word-out FIFO.
- Upstream side: accepts a valid/ready byte stream and drives the RAM write port (write_enable, write_addr, write_data).
- Downstream side: drives the RAM read_addr, takes the 64-bit async read_data and presents it as a valid/ready word stream.
- Tracks occupancy, applies backpressure when full and flags complete words only once they are fully written.

Parameters:
- WADDR_W, 9, RAM byte-address width (512 bytes).
- RADDR_W, 6, RAM word-address width (64 words). WADDR_W-RADDR_W must equal 3 (8 bytes per word).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  upstream byte valid
- s_ready  out  1  controller can accept a byte
- s_data  in  8  upstream byte
- s_last  in  1  last byte of a packet; used only with PAD_FLUSH_EN
- write_enable  out  1  RAM write strobe
- write_addr  out  WADDR_W  RAM byte address
- write_data  out  8  RAM write byte
- read_addr  out  RADDR_W  RAM word address (registered read pointer)
- read_data  in  64  RAM async read word
- m_valid  out  1  a complete word is available
- m_ready  in  1  downstream accepts the word
- m_data  out  64  equals read_data; byte 0 sits in [7:0]
- word_count  out  RADDR_W+1  committed, unpopped words (0..64)

Behaviour:
- Pointers (all cleared by reset):
  - wp: WADDR_W+1 bits, byte write pointer including a wrap bit.
  - cwp: RADDR_W+1 bits, committed-word pointer.
  - rp: RADDR_W+1 bits, word read pointer.
- Reset (rst_n=0 at a clk edge): all pointers 0, state RUN. Outputs: write_enable=0, write_addr=0, write_data=0, m_valid=0, word_count=0, s_ready=0 while rst_n=0. RAM contents are not cleared and are ignored. Reset mid-packet discards any partial word.
- Occupancy: used = wp - {rp,3'b000}, modulo 2^(WADDR_W+1).
- s_ready = rst_n & (state==RUN) & (used != 512). It is computed from registered state only, with no combinational path from m_ready.
- Byte accept, when s_valid & s_ready in cycle N:
  - Next edge registers write_enable=1, write_addr=wp[WADDR_W-1:0], write_data=s_data; wp increments.
  - The RAM write therefore happens at the end of cycle N+1.
  - write_enable is 0 in any cycle that follows no accept.
- Commit: at an edge where write_enable=1 and write_addr[2:0]==3'b111, cwp increments.
- Read side: m_valid = (cwp != rp). read_addr = rp[RADDR_W-1:0]. m_data = read_data.
- Latency: 8th byte of a word accepted in cycle N gives m_valid=1 in cycle N+2, with the full word on m_data.
- Pop: m_valid & m_ready increments rp at the edge. m_data must hold stable while m_valid=1 and m_ready=0.
- word_count = cwp - rp.
- Full: used==512, so s_ready=0. A pop in cycle N raises s_ready in cycle N+1. A simultaneous push attempt and pop at full loses no data.
- Empty: m_valid=0; m_ready is ignored.
- Wrap-around: pointers wrap modulo their width. Address 511 is followed by 0, and the wrap bit distinguishes full from empty.
- A partial word (fewer than 8 bytes written) is never visible downstream.

Optional Feature:
- Macro ASYM_FIFO_PAD_FLUSH_EN.
- Defined:
  - Two-state FSM, RUN and PAD.
  - Accepting a byte with s_last=1 where wp[2:0]!=3'b111 moves the FSM to PAD.
  - In PAD: s_ready=0. Each cycle the controller issues a zero byte (write_data=0x00) at wp and increments wp, until the byte at index 7 is issued; then it returns to RUN.
  - A packet tail is therefore committed zero-padded.
  - s_last on a byte at index 7 commits normally with no PAD.
  - PAD also stalls on full; it cannot be full mid-word by construction.
  - Reset during PAD returns the FSM to RUN.
- Undefined: s_last is ignored, there is no PAD state, and the FSM is always RUN.

Test Plan:
- Reset, then push bytes 0x00..0x07 back-to-back -> write_addr 0..7 on consecutive cycles; m_valid rises 2 cycles after the 0x07 accept; m_data=0x0706050403020100; word_count=1.
- Push 512 bytes with m_ready=0 -> s_ready=0 after the 512th accept and word_count=64. Then pop 1 -> s_ready=1 on the next cycle; the next byte writes address 0 (wrap).
- Streaming 1024 bytes with m_ready=1 and random s_valid gaps -> 128 words out, in order and byte-correct, with no m_valid during partial words.
- Push 5 bytes, assert rst_n=0 for 1 cycle, then push 8 bytes 0xA0..0xA7 -> first word out is 0xA7A6A5A4A3A2A1A0.
- m_valid=1 with m_ready held 0 for 10 cycles while pushes continue -> m_data is stable and unchanged.
- With ASYM_FIFO_PAD_FLUSH_EN: push 0x11,0x22,0x33 with s_last on 0x33 -> s_ready=0 for 5 cycles; word out is 0x0000000000332211.

Source files
------------

// File: rtl/asym_ram_byte_fifo_ctrl.sv
// asym_ram_byte_fifo_ctrl
//   Controls an 8-bit-write / 64-bit-async-read simple dual-port RAM and
//   makes it behave as a FIFO that takes bytes in and gives 64-bit words out.
//   A word becomes visible downstream only after all eight of its bytes have
//   been written to the RAM.
//
//   Optional feature macro: ASYM_FIFO_PAD_FLUSH_EN
//     When defined, a byte accepted with s_last closes the current word by
//     writing zero bytes up to the end of the word. When undefined, s_last
//     is ignored.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   s_valid, s_ready, s_data       upstream byte stream
//   s_last                         packet end marker (pad-flush build only)
//   write_enable/addr/data         RAM write port (registered)
//   read_addr, read_data           RAM async read port
//   m_valid, m_ready, m_data       downstream word stream (m_data = read_data)
//   word_count                     committed, unpopped words
//
// States
//   RUN | normal operation, upstream bytes accepted when not full
//   PAD | zero bytes are written to finish a partial word, upstream stalled
module asym_ram_byte_fifo_ctrl #(
  parameter int WADDR_W = 9,
  parameter int RADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic                 write_enable,
  output logic [WADDR_W-1:0]   write_addr,
  output logic [7:0]           write_data,
  output logic [RADDR_W-1:0]   read_addr,
  input  logic [63:0]          read_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [63:0]          m_data,
  output logic [RADDR_W:0]     word_count
);

  localparam int BSEL_W = WADDR_W - RADDR_W;
  localparam logic [WADDR_W:0] CAP      = {1'b1, {WADDR_W{1'b0}}};
  localparam logic [WADDR_W:0] WP_ONE   = (WADDR_W+1)'(1);
  localparam logic [RADDR_W:0] WORD_ONE = (RADDR_W+1)'(1);

  typedef enum logic {RUN, PAD} state_t;

  state_t           state;
  logic [WADDR_W:0] wp;
  logic [RADDR_W:0] cwp;
  logic [RADDR_W:0] rp;

  logic [WADDR_W:0] used;
  logic             full;
  logic             accept;
  logic             pop;
  logic             word_end;

  // Byte occupancy counts partially written words too, so a word slot is
  // never reused while any of its bytes are still pending.
  assign used     = wp - {rp, {BSEL_W{1'b0}}};
  assign full     = (used == CAP);
  assign s_ready  = rst_n & (state == RUN) & ~full;
  assign accept   = s_valid & s_ready;
  assign word_end = (wp[BSEL_W-1:0] == {BSEL_W{1'b1}});

  assign m_valid    = (cwp != rp);
  assign pop        = m_valid & m_ready;
  assign read_addr  = rp[RADDR_W-1:0];
  assign m_data     = read_data;
  assign word_count = cwp - rp;

`ifndef ASYM_FIFO_PAD_FLUSH_EN
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      wp           <= '0;
      cwp          <= '0;
      rp           <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= 1'b0;
      if (accept) begin
        write_enable <= 1'b1;
        write_addr   <= wp[WADDR_W-1:0];
        write_data   <= s_data;
        wp           <= wp + WP_ONE;
`ifdef ASYM_FIFO_PAD_FLUSH_EN
        if (s_last && !word_end) state <= PAD;
`endif
      end
`ifdef ASYM_FIFO_PAD_FLUSH_EN
      else if (state == PAD && !full) begin
        write_enable <= 1'b1;
        write_addr   <= wp[WADDR_W-1:0];
        write_data   <= 8'h00;
        wp           <= wp + WP_ONE;
        if (word_end) state <= RUN;
      end
`endif
      // The word is committed on the edge that actually writes its last
      // byte, so the read side never sees a word before the RAM holds it.
      if (write_enable && write_addr[BSEL_W-1:0] == {BSEL_W{1'b1}})
        cwp <= cwp + WORD_ONE;
      if (pop)
        rp <= rp + WORD_ONE;
    end
  end

endmodule

// File: tb/tb_asym_ram_byte_fifo_ctrl.sv
module tb_asym_ram_byte_fifo_ctrl;
  localparam int WADDR_W = 9;
  localparam int RADDR_W = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [7:0]         s_data = '0;
  logic               s_last = 1'b0;
  logic               write_enable;
  logic [WADDR_W-1:0] write_addr;
  logic [7:0]         write_data;
  logic [RADDR_W-1:0] read_addr;
  logic [63:0]        read_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [63:0]        m_data;
  logic [RADDR_W:0]   word_count;

  asym_ram_byte_fifo_ctrl #(.WADDR_W(WADDR_W), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // RAM: byte writes on the clock, whole-word asynchronous reads.
  logic [7:0] mem [0:511];
  always @(posedge clk) if (write_enable) mem[write_addr] <= write_data;
  always_comb begin
    read_data = '0;
    for (int i = 0; i < 8; i++) read_data[i*8 +: 8] = mem[{read_addr, 3'(i)}];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: bytes in order, grouped by eight into words.
  logic [7:0]  part[$];
  logic [63:0] exp_q[$];
  int          used_m = 0;
  int          wp_m = 0;
  int          pad_left = 0;
  bit          prev_we = 0;
  logic [8:0]  prev_addr = '0;
  logic [7:0]  prev_data = '0;
  int          pops = 0;

  task automatic issue(input logic [7:0] b);
    logic [63:0] w;
    prev_we   = 1;
    prev_addr = 9'(wp_m % 512);
    prev_data = b;
    wp_m++;
    used_m++;
    part.push_back(b);
    if (part.size() == 8) begin
      w = '0;
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = part[i];
      exp_q.push_back(w);
      part.delete();
    end
  endtask

  always @(negedge clk) begin
    bit exp_ready;
    int idx;
    if (!rst_n) begin
      check(s_ready == 1'b0, "s_ready_in_reset", 64'(s_ready), 64'd0);
      part.delete();
      exp_q.delete();
      used_m = 0; wp_m = 0; pad_left = 0; prev_we = 0;
    end else begin
      exp_ready = (pad_left == 0) && (used_m != 512);
      check(s_ready == exp_ready, "s_ready", 64'(s_ready), 64'(exp_ready));
      if (prev_we)
        check(write_enable && write_addr == prev_addr && write_data == prev_data, "write_port",
              {47'd0, write_enable, write_addr, write_data}, {47'd0, 1'b1, prev_addr, prev_data});
      else
        check(!write_enable, "write_idle", 64'(write_enable), 64'd0);
      prev_we = 0;
      if (pad_left > 0) begin
        issue(8'h00);
        pad_left--;
      end else if (s_valid && exp_ready) begin
        idx = part.size();
        issue(s_data);
`ifdef ASYM_FIFO_PAD_FLUSH_EN
        if (s_last && idx != 7) pad_left = 7 - idx;
`endif
      end
      if (m_valid && m_ready) used_m -= 8;
    end
  end

  // Monitor: every presented word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) check(1'b0, "m_valid_without_word", 64'(m_valid), 64'd0);
      else begin
        check(m_data == exp_q[0], "m_data", m_data, exp_q[0]);
        if (m_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit last);
    int t = 0;
    s_valid = 1; s_data = b; s_last = last;
    @(negedge clk);
    while (!s_ready && t < 5000) begin @(negedge clk); t++; end
    if (!s_ready) check(1'b0, "push_timeout", 64'(t), 64'd0);
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_valid();
    int t = 0;
    @(negedge clk);
    while (!m_valid && t < 100) begin @(negedge clk); t++; end
    check(m_valid, "m_valid_timeout", 64'(m_valid), 64'd1);
  endtask

  task automatic drain();
    int t = 0;
    @(posedge clk); #1;
    m_ready = 1;
    while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    check(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    m_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; s_valid = 0; s_last = 0; m_ready = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check(!write_enable && write_addr == 0 && write_data == 0, "reset_write_port",
          {47'd0, write_enable, write_addr, write_data}, 64'd0);
    check(!m_valid, "reset_m_valid", 64'(m_valid), 64'd0);
    check(word_count == 0, "reset_word_count", 64'(word_count), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [63:0] hold;

  initial begin
    // 1: first word and its latency
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(i), 0);
    @(negedge clk);
    check(!m_valid, "m_valid_early", 64'(m_valid), 64'd0);
    @(negedge clk);
    check(m_valid, "m_valid_latency", 64'(m_valid), 64'd1);
    check(m_data == 64'h0706050403020100, "first_word", m_data, 64'h0706050403020100);
    check(word_count == 1, "word_count_one", 64'(word_count), 64'd1);

    // 2: fill to full, pop one with a push pending, wrap to address 0
    do_reset();
    for (int i = 0; i < 512; i++) push(8'($urandom), 0);
    @(negedge clk);
    check(!s_ready, "full_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk); @(negedge clk);
    check(word_count == 64, "full_word_count", 64'(word_count), 64'd64);
    @(posedge clk); #1;
    s_valid = 1; s_data = 8'h5A; m_ready = 1;
    @(negedge clk);
    check(!s_ready && m_valid, "full_pop_cycle", {62'd0, s_ready, m_valid}, 64'd1);
    @(posedge clk); #1;
    m_ready = 0;
    @(negedge clk);
    check(s_ready, "s_ready_after_pop", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_valid = 0;
    @(negedge clk);
    check(write_enable && write_addr == 0 && write_data == 8'h5A, "wrap_addr",
          {47'd0, write_enable, write_addr, write_data}, {47'd0, 1'b1, 9'd0, 8'h5A});
    drain();

    // 3: stream 1024 bytes with random gaps
    do_reset();
    m_ready = 1;
    pops = 0;
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      push(8'($urandom), 0);
    end
    drain();
    check(pops == 128, "stream_word_total", 64'(pops), 64'd128);
    @(negedge clk);
    check(word_count == 0, "stream_word_count", 64'(word_count), 64'd0);
    @(posedge clk); #1;

    // 4: reset discards a partial word
    do_reset();
    for (int i = 0; i < 5; i++) push(8'($urandom), 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i), 0);
    wait_valid();
    check(m_data == 64'hA7A6A5A4A3A2A1A0, "word_after_reset", m_data, 64'hA7A6A5A4A3A2A1A0);
    @(posedge clk); #1;

    // 5: m_data holds while stalled and pushes continue
    do_reset();
    for (int i = 0; i < 8; i++) push(8'($urandom), 0);
    wait_valid();
    hold = m_data;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) push(8'($urandom), 0);
    @(negedge clk);
    check(m_data == hold, "m_data_hold", m_data, hold);
    @(posedge clk); #1;

    // random traffic with random backpressure and random s_last
    fork
      begin
        repeat (3000) begin @(posedge clk); #1; m_ready = 1'($urandom_range(1)); end
      end
      begin
        for (int i = 0; i < 1200; i++) begin
          if ($urandom_range(2) == 0) begin @(posedge clk); #1; end
          push(8'($urandom), ($urandom_range(9) == 0));
        end
      end
    join
    drain();

`ifdef ASYM_FIFO_PAD_FLUSH_EN
    // 6: packet tail padded with zeros
    do_reset();
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(!s_ready, "pad_stall", 64'(s_ready), 64'd0);
    end
    @(negedge clk);
    check(s_ready, "pad_done", 64'(s_ready), 64'd1);
    wait_valid();
    check(m_data == 64'h0000000000332211, "pad_word", m_data, 64'h0000000000332211);
    @(posedge clk); #1;
    drain();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), (i == 7));
    @(negedge clk);
    check(s_ready, "last_on_word_end", 64'(s_ready), 64'd1);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
